// File: rtl/inst_loader_pkg.sv
// Shared definitions for the instruction loader, instruction memory and processor top.
package inst_loader_pkg;

   // Default instruction-memory word-address width (32 words).
   localparam int DEF_ADDR_WIDTH = 5;

   // Loader FSM state encoding.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LEN    = 3'd1,
      ST_DATA   = 3'd2,
      ST_WRITE  = 3'd3,
      ST_FINISH = 3'd4,
      ST_FAIL   = 3'd5
   } state_e;

   // Storage byte order: program bytes arrive instruction-MSB-first and are
   // shifted in from the top, so the first byte of a word sits in [7:0].
   // The read side flips the bytes back to recover the instruction.
   function automatic logic [31:0] storage_to_instr(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

endpackage

// File: rtl/inst_loader_word_assembler.sv
// Collects four bytes into a storage-order word and flags the 4th byte.
module word_assembler (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        clr_i,
   input  logic        shift_i,
   input  logic [7:0]  byte_i,
   output logic [31:0] word_o,
   output logic        word_ready_o
);

   logic [31:0] shreg_q, shreg_d;
   logic [1:0]  cnt_q, cnt_d;

   // Next-state: shift a byte in from the top, counter wraps 3->0.
   always_comb begin
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      if (clr_i) begin
         cnt_d = 2'd0;
      end else if (shift_i) begin
         shreg_d = {byte_i, shreg_q[31:8]};
         cnt_d   = cnt_q + 2'd1;
      end
   end

   // Shift register and byte counter state.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         shreg_q <= 32'd0;
         cnt_q   <= 2'd0;
      end else begin
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
      end
   end

   assign word_o       = shreg_q;
   assign word_ready_o = shift_i && (cnt_q == 2'd3);

endmodule

// File: rtl/inst_loader.sv
// Streams a length-prefixed byte program into instruction memory while
// holding the processor in reset.
module inst_loader
   import inst_loader_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int MAX_WORDS  = 2**ADDR_WIDTH
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [7:0]  byte_in,
   input  logic        byte_valid,
   output logic        byte_ready,
   output logic        wr_en,
   output logic [31:0] wr_addr,
   output logic [31:0] wr_data,
   output logic        cpu_hold,
   output logic        done,
   output logic        error
);

   // Byte address space of the memory; keeps wr_addr inside it.
   localparam logic [31:0] ADDR_MASK = 32'((64'd1 << (ADDR_WIDTH + 2)) - 64'd1);

   state_e      state_q, state_d;
   logic [7:0]  len_q, index_q;
   logic [31:0] wr_addr_q;
   logic        done_q, error_q;
   logic        xfer, word_ready, clr_cnt, shift;

   assign xfer    = byte_valid && byte_ready;
   assign clr_cnt = (state_q == ST_IDLE) && start;
   assign shift   = (state_q == ST_DATA) && xfer;

   word_assembler u_asm (
      .clk_i        (clock),
      .rst_i        (reset),
      .clr_i        (clr_cnt),
      .shift_i      (shift),
      .byte_i       (byte_in),
      .word_o       (wr_data),
      .word_ready_o (word_ready)
   );

   // State register; reset wins over everything, including mid-load.
   always_ff @(posedge clock) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic; a missing byte_valid simply stalls LEN/DATA.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (start) state_d = ST_LEN;
         ST_LEN:    if (xfer) begin
                       if (byte_in == 8'd0)              state_d = ST_FINISH;
                       else if (32'(byte_in) > MAX_WORDS) state_d = ST_FAIL;
                       else                              state_d = ST_DATA;
                    end
         ST_DATA:   if (word_ready) state_d = ST_WRITE;
         ST_WRITE:  state_d = (index_q == len_q - 8'd1) ? ST_FINISH : ST_DATA;
         ST_FINISH: state_d = ST_IDLE;
         ST_FAIL:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Per-state handshake, hold and write strobe.
   always_comb begin
      byte_ready = 1'b0;
      cpu_hold   = 1'b0;
      wr_en      = 1'b0;
      case (state_q)
         ST_LEN, ST_DATA: begin byte_ready = 1'b1; cpu_hold = 1'b1; end
         ST_WRITE:        begin cpu_hold = 1'b1; wr_en = 1'b1; end
         default: ;
      endcase
   end

   // Length, word index, write address and sticky status flags.
   always_ff @(posedge clock) begin
      if (reset) begin
         len_q     <= 8'd0;
         index_q   <= 8'd0;
         wr_addr_q <= 32'd0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         if (clr_cnt) begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            index_q <= 8'd0;
         end
         if ((state_q == ST_LEN) && xfer) len_q <= byte_in;
         // Address is latched as the word completes so it is stable in WRITE.
         if ((state_q == ST_DATA) && word_ready)
            wr_addr_q <= {22'd0, index_q, 2'b00} & ADDR_MASK;
         if (state_q == ST_WRITE) index_q <= index_q + 8'd1;
         if ((state_q != ST_FINISH) && (state_d == ST_FINISH)) done_q  <= 1'b1;
         if ((state_q != ST_FAIL)   && (state_d == ST_FAIL))   error_q <= 1'b1;
      end
   end

   assign wr_addr = wr_addr_q;
   assign done    = done_q;
   assign error   = error_q;

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: directed loads plus random programs
// compared against a byte-stream model of the expected memory writes.
module tb_inst_loader;

   logic        clock = 1'b0;
   logic        reset, start, byte_valid;
   logic [7:0]  byte_in;
   logic        byte_ready, wr_en, cpu_hold, done, error;
   logic [31:0] wr_addr, wr_data;

   int tests = 0;
   int fails = 0;
   logic [63:0] wq[$];

   inst_loader dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .byte_in    (byte_in),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .cpu_hold   (cpu_hold),
      .done       (done),
      .error      (error)
   );

   always #5 clock = ~clock;

   // Log every memory write seen on the bus.
   always @(negedge clock) if (wr_en === 1'b1) wq.push_back({wr_addr, wr_data});

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
   endtask

   task automatic xfer(input logic [7:0] b);
      int n;
      n = 0;
      byte_in    = b;
      byte_valid = 1'b1;
      while (byte_ready !== 1'b1 && n < 20) begin
         @(negedge clock);
         n++;
      end
      if (n >= 20) check("ready_timeout", 32'(n), 32'd0);
      @(negedge clock);
      byte_valid = 1'b0;
   endtask

   // Model: word i is bytes 4i..4i+3 with the first-received byte in [7:0].
   task automatic check_writes(input string tag, input logic [7:0] prog[$], input int n);
      logic [31:0] exp;
      check({tag, "_nwr"}, 32'(wq.size()), 32'(n));
      for (int i = 0; i < n && i < wq.size(); i++) begin
         exp = {prog[4*i+3], prog[4*i+2], prog[4*i+1], prog[4*i]};
         check({tag, "_addr"}, wq[i][63:32], 32'(4*i));
         check({tag, "_data"}, wq[i][31:0], exp);
      end
   endtask

   // Full load of prog; optional long stall / stray start before byte idx.
   task automatic run_prog(input string tag, input logic [7:0] prog[$],
                           input int stall_at, input int start_at, input bit rnd_gaps);
      int n, k;
      n = prog.size() / 4;
      wq.delete();
      pulse_start();
      check({tag, "_done_clr"}, 32'(done), 32'd0);
      check({tag, "_hold"}, 32'(cpu_hold), 32'd1);
      xfer(8'(n));
      for (int i = 0; i < 4*n; i++) begin
         if (rnd_gaps) repeat ($urandom_range(0, 2)) @(negedge clock);
         if (i == stall_at) begin
            repeat (5) @(negedge clock);
            check({tag, "_stall_rdy"}, 32'(byte_ready), 32'd1);
            check({tag, "_stall_nwr"}, 32'(wq.size()), 32'(i / 4));
         end
         if (i == start_at) begin
            pulse_start();
            check({tag, "_start_ign"}, 32'(cpu_hold), 32'd1);
         end
         xfer(prog[i]);
      end
      k = 0;
      while (done !== 1'b1 && k < 10) begin
         @(negedge clock);
         k++;
      end
      check({tag, "_done"}, 32'(done), 32'd1);
      check({tag, "_err"}, 32'(error), 32'd0);
      check({tag, "_hold_off"}, 32'(cpu_hold), 32'd0);
      @(negedge clock);
      check({tag, "_idle"}, 32'(byte_ready), 32'd0);
      check_writes(tag, prog, n);
   endtask

   task automatic rand_prog(input int n, output logic [7:0] p[$]);
      p.delete();
      for (int i = 0; i < 4*n; i++) p.push_back(8'($urandom_range(0, 255)));
   endtask

   initial begin
      logic [7:0] prog[$];
      reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
      repeat (2) @(negedge clock);
      reset = 1'b0;

      // Reset state
      check("rst_ready", 32'(byte_ready), 32'd0);
      check("rst_wren",  32'(wr_en), 32'd0);
      check("rst_addr",  wr_addr, 32'd0);
      check("rst_data",  wr_data, 32'd0);
      check("rst_hold",  32'(cpu_hold), 32'd0);
      check("rst_done",  32'(done), 32'd0);
      check("rst_err",   32'(error), 32'd0);

      // Directed two-word program
      prog = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h02, 8'h00, 8'h00};
      run_prog("dir2", prog, -1, -1, 1'b0);
      check("dir2_w0", wq.size() > 0 ? wq[0][31:0] : 32'hx, 32'h05000820);
      check("dir2_w1", wq.size() > 1 ? wq[1][31:0] : 32'hx, 32'h0000028C);

      // Same program with a 5-cycle stall mid-word
      run_prog("stall", prog, 2, -1, 1'b0);

      // Zero-length load
      wq.delete();
      pulse_start();
      xfer(8'h00);
      check("n0_done1", 32'(done), 32'd1);
      check("n0_err",   32'(error), 32'd0);
      check("n0_hold",  32'(cpu_hold), 32'd0);
      @(negedge clock);
      check("n0_done2", 32'(done), 32'd1);
      check("n0_idle",  32'(byte_ready), 32'd0);
      check("n0_nwr",   32'(wq.size()), 32'd0);

      // Over-length load (MAX_WORDS = 32)
      wq.delete();
      pulse_start();
      xfer(8'h21);
      check("big_err",  32'(error), 32'd1);
      check("big_done", 32'(done), 32'd0);
      check("big_hold", 32'(cpu_hold), 32'd0);
      @(negedge clock);
      check("big_err2", 32'(error), 32'd1);
      check("big_idle", 32'(byte_ready), 32'd0);
      pulse_start();
      check("big_errclr", 32'(error), 32'd0);
      xfer(8'hFF);
      check("ff_err", 32'(error), 32'd1);
      @(negedge clock);
      check("ovr_nwr", 32'(wq.size()), 32'd0);

      // Reset in the middle of word 1
      rand_prog(2, prog);
      wq.delete();
      pulse_start();
      xfer(8'd2);
      for (int i = 0; i < 6; i++) xfer(prog[i]);
      reset = 1'b1;
      @(negedge clock);
      check("mrst_ready", 32'(byte_ready), 32'd0);
      check("mrst_wren",  32'(wr_en), 32'd0);
      check("mrst_addr",  wr_addr, 32'd0);
      check("mrst_data",  wr_data, 32'd0);
      check("mrst_hold",  32'(cpu_hold), 32'd0);
      check("mrst_flags", 32'({done, error}), 32'd0);
      reset = 1'b0;
      @(negedge clock);
      check_writes("mrst", prog, 1);

      // Stray start during DATA
      rand_prog(3, prog);
      run_prog("sdata", prog, -1, 5, 1'b0);

      // Largest accepted length
      rand_prog(32, prog);
      run_prog("max", prog, -1, -1, 1'b0);

      // Random programs with random valid gaps
      for (int r = 0; r < 4; r++) begin
         rand_prog($urandom_range(1, 8), prog);
         run_prog("rnd", prog, -1, -1, 1'b1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Absolute guard so the run always ends.
   initial begin
      #500000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
